conv_encoder_k3: RTL and testbench
==================================

# conv_encoder_k3

Rate-1/2, constraint-length-3 convolutional encoder with generators G0 = 7 (octal, 111) and G1 = 5 (octal, 101). It is the transmit-side counterpart of the 4-state Viterbi decoder, and its trellis matches the decoder's ACS state numbering. It accepts one information bit per valid/ready handshake and emits one 2-bit code symbol per handshake. At frame end it appends two zero tail bits, which returns the trellis to state 00.

## Interface
- TAIL_EN, default 1: 1 appends K-1 = 2 zero tail bits after each frame; 0 sends no tail, and the encoder state is still cleared to 00 after the last bit.
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit/in_last are valid.
- in_ready  output  1  encoder accepts a bit this cycle.
- in_bit  input  1  information bit u.
- in_last  input  1  marks the last information bit of a frame.
- out_valid  output  1  out_symbol is valid.
- out_ready  input  1  downstream accepts a symbol.
- out_symbol  output  2  {c0, c1} code symbol.
- out_last  output  1  marks the final symbol of the frame (last tail symbol, or the last data symbol when TAIL_EN = 0).
- busy  output  1  high while in TAIL state or while out_valid = 1.

## Operation
- **Trellis state** is s = {s1, s0}: s1 is the most recent input bit, s0 the one before. Reset value is 00.
- **Encoding**:
  - c0 = u ^ s1 ^ s0
  - c1 = u ^ s0
  - next s = {u, s1}
  - Resulting predecessors: state 00 from 00/01, state 01 from 10/11, state 10 from 00/01, state 11 from 10/11.
- **FSM states**: IDLE, DATA, TAIL.
  - IDLE -> DATA on the first accepted bit with in_last = 0.
  - IDLE or DATA -> TAIL on an accepted bit with in_last = 1, when TAIL_EN = 1.
  - IDLE or DATA -> IDLE on an accepted bit with in_last = 1, when TAIL_EN = 0. The trellis state is forced to 00 and out_last is set on that symbol.
  - TAIL: the encoder internally generates two symbols with u = 0, using a 1-bit tail counter. Each is generated only when the output register can load. out_last is set on the second. Then TAIL -> IDLE, and s is 00 by construction.
- **Output register**: a single stage holding out_symbol, out_valid and out_last. It loads when (!out_valid || out_ready).
- **in_ready** = (state != TAIL) && (!out_valid || out_ready). An input transfer occurs when in_valid && in_ready.
- **Backpressure**: while out_valid && !out_ready, out_symbol, out_last and the trellis state hold. No bit is accepted and no tail symbol is generated.
- **Reset**, including mid-frame: the FSM goes to IDLE, s = 00, tail counter = 0, and out_valid, out_last, out_symbol and busy all become 0. Any partial frame is discarded and nothing is flushed.
- in_bit/in_last are ignored when in_valid = 0.

## Timing
- Latency is 1 cycle: a bit accepted at edge n produces out_valid with its symbol after edge n.
- Full throughput is 1 symbol per cycle when out_ready is held at 1.
- A frame of N bits yields N + 2 symbols (N when TAIL_EN = 0).
- in_ready is low for exactly 2 load cycles after the last bit (tail), stretched by any backpressure.
- The first bit of the next frame can be accepted in the cycle the second tail symbol is consumed. Frames are back-to-back with no dead cycle beyond the tail.
- Simultaneous out_ready and an input transfer in the same cycle: the old symbol is consumed and the new symbol is loaded, with no bubble.
- in_last on the first bit of a frame (1-bit frame) is legal.

## Test plan
- **Reference frame**: after reset, bits 1,0,1,1 (last on the 4th), out_ready = 1 -> symbols 11, 10, 00, 01, 01, 11 on consecutive cycles. out_last = 1 only on the 6th symbol. in_ready = 0 for 2 cycles after the 4th bit.
- **1-bit frame**: bit 1 with in_last = 1 -> symbols 11, 10, 11, out_last on the third, s = 00 afterwards. The next frame starts from state 00.
- **Backpressure**: reference frame with out_ready = 0 for 3 cycles after the 2nd symbol -> symbol 10 held stable for those 3 cycles, no input accepted. The sequence completes unchanged.
- **TAIL_EN = 0**: bits 1,1 with last on the 2nd -> symbols 11, 01, out_last on 01. A following frame with bit 1 -> 11, confirming the state was cleared.
- **Mid-frame reset**: assert rst after bits 1,0 -> next cycle out_valid = 0, busy = 0, in_ready = 1. A new frame with bit 0,0 (last on the 2nd) -> 00, 00, 00, 00.
- **Random frames**: random frames with random in_valid/out_ready checked against a bit-accurate model. Every frame, fed through the Viterbi decoder, must return its original bits.

Source files
------------

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder (G0 = 7, G1 = 5) with a single-stage output
// register and optional two-bit zero tail that flushes the trellis back to state 00.
module conv_encoder_k3 #(
    parameter bit TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_symbol,
    output logic       out_last,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    state_t     state, state_next;
    logic [1:0] trellis, trellis_next;
    logic       tail_cnt, tail_cnt_next;
    logic [1:0] symbol_next;
    logic       valid_next, last_next;
    logic       load, in_fire, u;
    logic [1:0] code;

    assign load     = !out_valid || out_ready;
    assign in_ready = (state != TAIL) && load;
    assign in_fire  = in_valid && in_ready;
    assign busy     = (state == TAIL) || out_valid;

    // Tail symbols are the same trellis step with the input forced to zero.
    assign u    = (state == TAIL) ? 1'b0 : in_bit;
    assign code = {u ^ trellis[1] ^ trellis[0], u ^ trellis[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            trellis    <= 2'b00;
            tail_cnt   <= 1'b0;
            out_valid  <= 1'b0;
            out_symbol <= 2'b00;
            out_last   <= 1'b0;
        end else begin
            state      <= state_next;
            trellis    <= trellis_next;
            tail_cnt   <= tail_cnt_next;
            out_valid  <= valid_next;
            out_symbol <= symbol_next;
            out_last   <= last_next;
        end
    end

    always_comb begin
        state_next    = state;
        trellis_next  = trellis;
        tail_cnt_next = tail_cnt;
        symbol_next   = out_symbol;
        valid_next    = out_valid;
        last_next     = out_last;

        if (load) begin
            valid_next = 1'b0;
            last_next  = 1'b0;
        end

        case (state)
            IDLE, DATA: begin
                if (in_fire) begin
                    valid_next   = 1'b1;
                    symbol_next  = code;
                    trellis_next = {u, trellis[1]};
                    if (!in_last) begin
                        state_next = DATA;
                    end else if (TAIL_EN) begin
                        state_next    = TAIL;
                        tail_cnt_next = 1'b0;
                    end else begin
                        // Without a tail the trellis is cleared directly so the next frame starts at 00.
                        state_next   = IDLE;
                        trellis_next = 2'b00;
                        last_next    = 1'b1;
                    end
                end
            end
            TAIL: begin
                if (load) begin
                    valid_next   = 1'b1;
                    symbol_next  = code;
                    trellis_next = {1'b0, trellis[1]};
                    if (tail_cnt) begin
                        last_next     = 1'b1;
                        tail_cnt_next = 1'b0;
                        state_next    = IDLE;
                    end else begin
                        tail_cnt_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Directed and randomised bench for conv_encoder_k3; one instance with tail, one without,
// checked against hand-computed symbols, a bit-level model and a small Viterbi decoder.
module tb_conv_encoder_k3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid1 = 1'b0, in_bit1 = 1'b0, in_last1 = 1'b0, out_ready1 = 1'b1;
    logic       in_ready1, out_valid1, out_last1, busy1;
    logic [1:0] out_symbol1;
    logic       in_valid0 = 1'b0, in_bit0 = 1'b0, in_last0 = 1'b0, out_ready0 = 1'b1;
    logic       in_ready0, out_valid0, out_last0, busy0;
    logic [1:0] out_symbol0;

    logic       s_valid1, s_last1, s_rdy1, s_busy1, s_valid0, s_rdy0, s_busy0;
    logic [1:0] s_sym1;
    logic [2:0] got1[$];
    logic [2:0] got0[$];
    logic [2:0] expq[$];
    logic       rand_mode = 1'b0;
    int         checks = 0;
    int         passes = 0;

    conv_encoder_k3 #(.TAIL_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_bit(in_bit1),
        .in_last(in_last1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_symbol(out_symbol1), .out_last(out_last1), .busy(busy1)
    );

    conv_encoder_k3 #(.TAIL_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_bit(in_bit0),
        .in_last(in_last0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_symbol(out_symbol0), .out_last(out_last0), .busy(busy0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: sample and log symbol transfers at the falling edge, then advance past the rising edge.
    task automatic tick();
        @(negedge clk);
        s_valid1 = out_valid1; s_sym1 = out_symbol1; s_last1 = out_last1;
        s_rdy1 = in_ready1; s_busy1 = busy1;
        s_valid0 = out_valid0; s_rdy0 = in_ready0; s_busy0 = busy0;
        if (!rst && out_valid1 && out_ready1) got1.push_back({out_last1, out_symbol1});
        if (!rst && out_valid0 && out_ready0) got0.push_back({out_last0, out_symbol0});
        @(posedge clk);
        #1;
        if (rand_mode) begin
            out_ready1 = 1'($urandom_range(0, 1));
            out_ready0 = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic applyStimulus(input logic which, input logic b, input logic l);
        logic accepted = 1'b0;
        if (which) begin in_valid1 = 1'b1; in_bit1 = b; in_last1 = l; end
        else begin in_valid0 = 1'b1; in_bit0 = b; in_last0 = l; end
        for (int n = 0; n < 200 && !accepted; n++) begin
            tick();
            accepted = which ? s_rdy1 : s_rdy0;
        end
        checkOutput("accept", 32'(accepted), 32'd1);
        if (which) in_valid1 = 1'b0;
        else in_valid0 = 1'b0;
    endtask

    task automatic waitIdle(input logic which);
        logic b = 1'b1;
        for (int n = 0; n < 300 && b; n++) begin
            tick();
            b = which ? s_busy1 : s_busy0;
        end
        checkOutput("drain", 32'(b), 32'd0);
    endtask

    task automatic checkQueue(input logic which, input string tag);
        logic [2:0] q[$];
        if (which) q = got1;
        else q = got0;
        checkOutput({tag, "_len"}, q.size(), expq.size());
        for (int i = 0; i < q.size() && i < expq.size(); i++)
            checkOutput($sformatf("%s_sym%0d", tag, i), 32'(q[i]), 32'(expq[i]));
        expq.delete();
        if (which) got1.delete();
        else got0.delete();
    endtask

    task automatic checkCycle(input string tag, input logic v, input logic [1:0] sym,
                              input logic l, input logic r);
        checkOutput({tag, "_valid"}, 32'(s_valid1), 32'(v));
        if (v) begin
            checkOutput({tag, "_sym"}, 32'(s_sym1), 32'(sym));
            checkOutput({tag, "_last"}, 32'(s_last1), 32'(l));
        end
        checkOutput({tag, "_ready"}, 32'(s_rdy1), 32'(r));
    endtask

    // Reference encoder: bits[0] is sent first.
    task automatic buildModel(input logic [31:0] bits, input int n, input logic tail);
        logic [1:0] s = 2'b00;
        logic       ub;
        for (int i = 0; i < n + (tail ? 2 : 0); i++) begin
            ub = (i < n) ? bits[i] : 1'b0;
            expq.push_back({(tail ? (i == n + 1) : (i == n - 1)), ub ^ s[1] ^ s[0], ub ^ s[0]});
            s = {ub, s[1]};
        end
    endtask

    // Hard-decision Viterbi over the received tailed frame, ending in state 00.
    task automatic viterbiCheck(input logic [31:0] bits, input int n);
        int          pm[4], npm[4], m;
        logic [31:0] hist[4], nhist[4];
        logic [1:0]  nsv, ps, c;
        logic        ub;
        logic [31:0] mask;
        pm = '{0, 1000, 1000, 1000};
        hist = '{default: '0};
        nhist = '{default: '0};
        for (int t = 0; t < got1.size() && t < 32; t++) begin
            for (int ns = 0; ns < 4; ns++) begin
                npm[ns] = 1 << 30;
                nsv = 2'(ns);
                ub = nsv[1];
                for (int p0 = 0; p0 < 2; p0++) begin
                    ps = {nsv[0], 1'(p0)};
                    c = {ub ^ ps[1] ^ ps[0], ub ^ ps[0]};
                    m = pm[ps] + int'(c[1] != got1[t][1]) + int'(c[0] != got1[t][0]);
                    if (m < npm[ns]) begin
                        npm[ns] = m;
                        nhist[ns] = hist[ps] | (32'(ub) << t);
                    end
                end
            end
            pm = npm;
            hist = nhist;
        end
        mask = (32'd1 << n) - 32'd1;
        checkOutput("viterbi_bits", hist[0] & mask, bits & mask);
    endtask

    initial begin
        logic [31:0] bits;
        int          n, gaps;

        tick();
        tick();
        checkOutput("rst_valid", 32'(s_valid1), 32'd0);
        checkOutput("rst_busy", 32'(s_busy1), 32'd0);
        checkOutput("rst_ready", 32'(s_rdy1), 32'd1);
        checkOutput("rst_busy0", 32'(s_busy0), 32'd0);
        rst = 1'b0;

        $display("[TB] reference frame");
        in_valid1 = 1'b1; in_bit1 = 1'b1; in_last1 = 1'b0;
        tick(); checkCycle("ref_c0", 1'b0, 2'b00, 1'b0, 1'b1);
        in_bit1 = 1'b0;
        tick(); checkCycle("ref_c1", 1'b1, 2'b11, 1'b0, 1'b1);
        in_bit1 = 1'b1;
        tick(); checkCycle("ref_c2", 1'b1, 2'b10, 1'b0, 1'b1);
        in_last1 = 1'b1;
        tick(); checkCycle("ref_c3", 1'b1, 2'b00, 1'b0, 1'b1);
        in_valid1 = 1'b0; in_last1 = 1'b0;
        tick(); checkCycle("ref_c4", 1'b1, 2'b01, 1'b0, 1'b0);
        tick(); checkCycle("ref_c5", 1'b1, 2'b01, 1'b0, 1'b0);
        tick(); checkCycle("ref_c6", 1'b1, 2'b11, 1'b1, 1'b1);
        tick(); checkCycle("ref_c7", 1'b0, 2'b00, 1'b0, 1'b1);
        checkOutput("ref_idle_busy", 32'(s_busy1), 32'd0);
        expq = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        checkQueue(1'b1, "ref");

        $display("[TB] one-bit frames");
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitIdle(1'b1);
        expq = '{3'b011, 3'b010, 3'b111, 3'b011, 3'b010, 3'b111};
        checkQueue(1'b1, "onebit");

        $display("[TB] backpressure");
        in_valid1 = 1'b1; in_bit1 = 1'b1; in_last1 = 1'b0;
        tick();
        in_bit1 = 1'b0;
        tick();
        in_bit1 = 1'b1; out_ready1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCycle($sformatf("bp_stall%0d", i), 1'b1, 2'b10, 1'b0, 1'b0);
        end
        out_ready1 = 1'b1;
        tick(); checkCycle("bp_release", 1'b1, 2'b10, 1'b0, 1'b1);
        in_valid1 = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitIdle(1'b1);
        expq = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        checkQueue(1'b1, "bp");

        $display("[TB] no-tail instance");
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitIdle(1'b0);
        expq = '{3'b011, 3'b101, 3'b111};
        checkQueue(1'b0, "notail");

        $display("[TB] mid-frame reset");
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("midrst_valid", 32'(s_valid1), 32'd0);
        checkOutput("midrst_busy", 32'(s_busy1), 32'd0);
        checkOutput("midrst_ready", 32'(s_rdy1), 32'd1);
        got1.delete();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitIdle(1'b1);
        expq = '{3'b000, 3'b000, 3'b000, 3'b100};
        checkQueue(1'b1, "midrst");

        $display("[TB] random frames");
        rand_mode = 1'b1;
        for (int f = 0; f < 12; f++) begin
            logic which;
            which = (f % 3 != 2);
            n = $urandom_range(1, 20);
            bits = $urandom;
            for (int i = 0; i < n; i++) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    in_bit1 = 1'($urandom_range(0, 1)); in_last1 = 1'($urandom_range(0, 1));
                    in_bit0 = 1'($urandom_range(0, 1)); in_last0 = 1'($urandom_range(0, 1));
                    tick();
                end
                applyStimulus(which, bits[i], i == n - 1);
            end
            waitIdle(which);
            buildModel(bits, n, which);
            if (which) viterbiCheck(bits, n);
            checkQueue(which, $sformatf("rand%0d", f));
        end
        rand_mode = 1'b0;
        out_ready1 = 1'b1;
        out_ready0 = 1'b1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
